// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for N_DIGITS common-cathode 7-segment digits.
// A hex word, a decimal-point mask and a blank mask are captured on load.
// Each digit slot lasts SCAN_DIV cycles. The first output cycle of every
// slot has all digit enables off, which prevents ghosting. During that gap
// the segment bus already carries the new digit's pattern.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   load         capture data_in / dp_in / blank_in on this edge
//   data_in      hex nibbles; nibble k = data_in[4k+3:4k]
//   dp_in        decimal point enable per digit
//   blank_in     force digit k dark (segments off, dp still shown)
//   lz_suppress  leading-zero suppression enable (used live, not latched)
//   seg_out      {dp, a, b, c, d, e, f, g}; 1 = lit (registered)
//   digit_sel    one-hot digit enable, bit k = digit k (registered)
//   frame_done   one-cycle pulse on the edge where the scan wraps to digit 0
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_suppress,
    output logic [7:0]            seg_out,
    output logic [N_DIGITS-1:0]   digit_sel,
    output logic                  frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg7_scan_driver: SCAN_DIV must be >= 2");
    end
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
        $error("seg7_scan_driver: N_DIGITS must be in 1..8");
    end

    // Hex nibble to segments {a,b,c,d,e,f,g}.
    function automatic logic [6:0] f_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h7E;
            4'h1: seg = 7'h30;
            4'h2: seg = 7'h6D;
            4'h3: seg = 7'h79;
            4'h4: seg = 7'h33;
            4'h5: seg = 7'h5B;
            4'h6: seg = 7'h5F;
            4'h7: seg = 7'h72;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h7B;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h1F;
            4'hC: seg = 7'h4E;
            4'hD: seg = 7'h3D;
            4'hE: seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]      r_div_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_data;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_blank;
    logic [7:0]            r_seg_out;
    logic [N_DIGITS-1:0]   r_digit_sel;
    logic                  r_frame_done;

    logic [N_DIGITS-1:0]   w_zero_from;
    logic [N_DIGITS-1:0]   w_onehot;
    logic [3:0]            w_nib;
    logic                  w_dp;
    logic                  w_blank;
    logic                  w_zero_run;
    logic                  w_suppress;
    logic [6:0]            w_seg;
    logic                  w_slot_end;
    logic                  w_idx_last;

    // w_zero_from[k] is set when nibbles N_DIGITS-1 down to k are all zero.
    // Only nibble values count here, so blanked digits still extend a run.
    always_comb begin
        logic run;
        run         = 1'b1;
        w_zero_from = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run            = run & (r_data[4*k +: 4] == 4'h0);
            w_zero_from[k] = run;
        end
    end

    // Select the current digit's fields. The explicit compare loop keeps the
    // mux well-defined when N_DIGITS is not a power of two.
    always_comb begin
        w_nib      = 4'h0;
        w_dp       = 1'b0;
        w_blank    = 1'b0;
        w_zero_run = 1'b0;
        w_onehot   = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_data[4*k +: 4];
                w_dp        = r_dp[k];
                w_blank     = r_blank[k];
                w_zero_run  = w_zero_from[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Digit 0 is never suppressed, so an all-zero word still shows "0".
    assign w_suppress = lz_suppress && (r_idx != '0) && w_zero_run;
    assign w_seg      = (w_blank || w_suppress) ? 7'h00 : f_seg7(w_nib);
    assign w_slot_end = (r_div_cnt == DIV_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_data       <= '0;
            r_dp         <= '0;
            r_blank      <= '0;
            r_seg_out    <= 8'h00;
            r_digit_sel  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (load) begin
                r_data  <= data_in;
                r_dp    <= dp_in;
                r_blank <= blank_in;
            end

            if (w_slot_end) begin
                r_div_cnt <= '0;
                r_idx     <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            // Outputs follow the state before this edge. A slot's first
            // cycle keeps all enables off while the segments settle.
            r_digit_sel  <= (r_div_cnt == '0) ? '0 : w_onehot;
            r_seg_out    <= {w_dp, w_seg};
            r_frame_done <= w_slot_end && w_idx_last;
        end
    end

    assign seg_out    = r_seg_out;
    assign digit_sel  = r_digit_sel;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int S   = 4;
    localparam int FRM = N * S;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [15:0]   data_in = 16'h0;
    logic [3:0]    dp_in = 4'h0;
    logic [3:0]    blank_in = 4'h0;
    logic          lz_suppress = 1'b0;
    logic [7:0]    seg_out;
    logic [3:0]    digit_sel;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.N_DIGITS(N), .SCAN_DIV(S)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_in(blank_in), .lz_suppress(lz_suppress), .seg_out(seg_out),
        .digit_sel(digit_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a time-slot view of the scan. ph is the position in
    // the frame (0..FRM-1) that the design is in before the next edge.
    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    int         ph = 0;
    bit         model_valid = 0;
    logic [15:0] m_data = 0;
    logic [3:0]  m_dp = 0, m_blank = 0;
    logic [7:0]  e_seg = 0;
    logic [3:0]  e_sel = 0;
    logic        e_fd = 0;

    always @(posedge clk) begin
        int d, c;
        logic [3:0] nib;
        bit sup;
        if (rst) begin
            m_data = 0; m_dp = 0; m_blank = 0; ph = 0;
            e_seg = 0; e_sel = 0; e_fd = 0;
        end else begin
            d   = ph / S;
            c   = ph % S;
            nib = 4'((m_data >> (4 * d)) & 16'hF);
            sup = lz_suppress && (d > 0) && ((m_data >> (4 * d)) == 0);
            e_sel = (c == 0) ? 4'h0 : 4'(1 << d);
            e_seg = {m_dp[d], (m_blank[d] || sup) ? 7'h00 : seg_tab[nib]};
            e_fd  = (ph == FRM - 1);
            ph    = (ph + 1) % FRM;
            if (load) begin
                m_data = data_in; m_dp = dp_in; m_blank = blank_in;
            end
        end
        model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model seg_out", {24'h0, seg_out}, {24'h0, e_seg});
            chk("model digit_sel", {28'h0, digit_sel}, {28'h0, e_sel});
            chk("model frame_done", {31'h0, frame_done}, {31'h0, e_fd});
        end
    end

    // Wait (bounded) until the DUT enables digit pattern sel, then check seg.
    task automatic wait_sel(input string name, input logic [3:0] sel, input logic [7:0] seg);
        bit found = 0;
        for (int i = 0; i < 3 * FRM && !found; i++) begin
            @(negedge clk);
            if (digit_sel == sel) found = 1;
        end
        if (found) chk(name, {24'h0, seg_out}, {24'h0, seg});
        else begin
            checks++; errors++;
            $display("FAIL %s: digit_sel never reached %b", name, sel);
        end
    endtask

    task automatic wait_ph(input int target);
        bit found = 0;
        for (int i = 0; i < 3 * FRM && !found; i++) begin
            @(negedge clk);
            if (ph == target) found = 1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wait_ph: phase %0d never reached", target);
        end
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        @(negedge clk);
        data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (FRM + 1) @(negedge clk);
    endtask

    logic [3:0]  idle_sel [6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
    logic [15:0] hex_words [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    logic [7:0]  hex_d3 [4] = '{8'h47, 8'h1F, 8'h72, 8'h79};
    logic [7:0]  hex_d0 [4] = '{8'h4E, 8'h7F, 8'h33, 8'h7E};

    initial begin
        int pulses, first;
        // Pin the model's segment table with hand values.
        chk("tab F", {25'h0, seg_tab[15]}, 32'h47);
        chk("tab 0", {25'h0, seg_tab[0]}, 32'h7E);
        chk("tab b", {25'h0, seg_tab[11]}, 32'h1F);

        // Reset and idle scan.
        repeat (3) @(negedge clk);
        chk("reset seg_out", {24'h0, seg_out}, 32'h0);
        chk("reset digit_sel", {28'h0, digit_sel}, 32'h0);
        chk("reset frame_done", {31'h0, frame_done}, 32'h0);
        rst = 1'b0;
        pulses = 0; first = 0;
        for (int i = 1; i <= 2 * FRM; i++) begin
            @(negedge clk);
            if (i <= 6) chk("idle digit_sel", {28'h0, digit_sel}, {28'h0, idle_sel[i-1]});
            if (i == 1) chk("idle seg_out", {24'h0, seg_out}, 32'h7E);
            if (frame_done) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("first frame_done cycle", first, 16);
        chk("frame_done pulses", pulses, 2);

        // Full hex table.
        for (int w = 0; w < 4; w++) begin
            load_word(hex_words[w], 4'h0, 4'h0);
            wait_sel("hex digit3", 4'b1000, hex_d3[w]);
            wait_sel("hex digit0", 4'b0001, hex_d0[w]);
        end

        // Decimal point and blank.
        load_word(16'h1234, 4'b0100, 4'b0001);
        wait_sel("dp digit3", 4'b1000, 8'h30);
        wait_sel("dp digit2", 4'b0100, 8'hED);
        wait_sel("dp digit1", 4'b0010, 8'h79);
        wait_sel("blank digit0", 4'b0001, 8'h00);

        // Leading-zero suppression.
        lz_suppress = 1'b1;
        load_word(16'h0050, 4'h0, 4'h0);
        wait_sel("lz digit3", 4'b1000, 8'h00);
        wait_sel("lz digit2", 4'b0100, 8'h00);
        wait_sel("lz digit1", 4'b0010, 8'h5B);
        wait_sel("lz digit0", 4'b0001, 8'h7E);
        // A blanked zero digit still continues the zero run.
        load_word(16'h0005, 4'h0, 4'b1000);
        wait_sel("lz blank digit1", 4'b0010, 8'h00);
        load_word(16'h0000, 4'h0, 4'h0);
        wait_sel("lz zero digit1", 4'b0010, 8'h00);
        wait_sel("lz zero digit0", 4'b0001, 8'h7E);
        lz_suppress = 1'b0;
        repeat (FRM + 1) @(negedge clk);
        wait_sel("no lz digit3", 4'b1000, 8'h7E);

        // Load timing: load while digit 0, slot cycle 2.
        wait_ph(2);
        data_in = 16'h0009; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load edge seg_out", {24'h0, seg_out}, 32'h7E);
        @(negedge clk);
        chk("load +1 seg_out", {24'h0, seg_out}, 32'h7B);

        // Mid-frame reset at digit 2, slot cycle 2.
        wait_ph(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst seg_out", {24'h0, seg_out}, 32'h0);
        chk("midrst digit_sel", {28'h0, digit_sel}, 32'h0);
        @(negedge clk);
        chk("restart gap sel", {28'h0, digit_sel}, 32'h0);
        chk("restart seg_out", {24'h0, seg_out}, 32'h7E);
        @(negedge clk);
        chk("restart digit0 sel", {28'h0, digit_sel}, 32'h1);

        // Simultaneous reset and load: reset wins.
        @(negedge clk);
        rst = 1'b1; load = 1'b1; data_in = 16'hFFFF;
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        repeat (FRM + 1) @(negedge clk);
        wait_sel("rst+load digit3", 4'b1000, 8'h7E);
        wait_sel("rst+load digit0", 4'b0001, 8'h7E);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
